fft32_frame_ctrl: RTL and testbench
===================================

// Module: fft32_frame_ctrl
// PURPOSE
//  Sequencer around the 32-point DIT FFT top (parallel in0..in31_r, out0..out31_r/_i).
//  Gathers a serial real-sample stream into a 32-sample frame and drives it as a stable parallel bus.
//  Waits the FFT pipeline latency, snapshots the 32 complex results, then streams them out serially, bin 0 first.
//  Single frame in flight. Sits between the sample source / result sink and the FFT top.
// PARAMETERS
//  N        16  sample / result word width, two's-complement fixed point
//  Q         8  fractional bits (pass-through only, no arithmetic done here)
//  FFT_LAT   6  clk2 cycles from stable FFT input to valid FFT output, >=1
// PORTS
//  clk2      in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-low reset
//  s_valid   in   1       input sample valid
//  s_ready   out  1       controller accepts a sample this cycle
//  s_data    in   N       real input sample
//  s_last    in   1       source marks the 32nd sample of a frame
//  fft_in    out  32*N    packed FFT inputs, sample k at [k*N +: N], to inK_r
//  fft_out_r in   32*N    packed FFT real outputs, bin k at [k*N +: N]
//  fft_out_i in   32*N    packed FFT imaginary outputs, same packing
//  m_valid   out  1       output bin valid
//  m_ready   in   1       sink accepts a bin
//  m_data_r  out  N       real part of bin m_index
//  m_data_i  out  N       imaginary part of bin m_index
//  m_index   out  5       bin number 0..31
//  m_last    out  1       high with bin 31
//  busy      out  1       high in WAIT, CAPT, UNLOAD
//  err_frame out  1       one-cycle pulse on a framing error
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wr_idx=rd_idx=0, lat_cnt=0.
//    Input buffer, output buffer and fft_in clear to 0.
//    s_ready, m_valid, m_last, busy, err_frame, m_index, m_data_* all 0.
//  - All outputs are registered or decoded from registered state; no comb path from s_valid/m_ready to s_ready/m_valid.
//  - IDLE: go to LOAD next cycle; s_ready=1 from the first cycle after reset release +1.
//  - LOAD: s_ready=1. On s_valid&s_ready: ibuf[wr_idx]<=s_data, wr_idx++.
//    - Accept at wr_idx=31 -> WAIT, lat_cnt<=FFT_LAT-1, wr_idx<=0.
//    - If s_last=0 at wr_idx=31: pulse err_frame, frame is still processed.
//    - If s_last=1 at wr_idx<31: pulse err_frame, discard the partial frame (wr_idx<=0), stay in LOAD.
//      The accepted sample is dropped.
//  - fft_in is driven from ibuf, updated only in LOAD, held constant from the WAIT entry through UNLOAD exit.
//  - WAIT: s_ready=0. lat_cnt decrements each cycle; at 0 -> CAPT.
//  - CAPT: one cycle. obuf_r/obuf_i<=fft_out_r/i (all 32 bins), rd_idx<=0 -> UNLOAD.
//  - UNLOAD: m_valid=1, m_data_*=obuf[rd_idx], m_index=rd_idx, m_last=(rd_idx==31).
//    - m_data/m_index are held stable while m_valid&!m_ready.
//    - On m_valid&m_ready: rd_idx++. Transfer of bin 31 -> LOAD, and m_valid drops the next cycle.
//  - Latency: last input accept (cycle T) -> first m_valid at T+FFT_LAT+2.
//  - Reset mid-operation: immediate return to reset values and the frame is lost; no partial output after release.
//  - No arithmetic, scaling or saturation here; widths pass unchanged.
// TESTING
//  1. Echo stub (fft_out_r=fft_in, out_i=~fft_in, FFT_LAT=6), samples 0..31, s_last on 31, m_ready=1
//     -> m_data_r=0..31, m_data_i=~k, m_index=0..31, m_last on 31 only, first m_valid exactly 8 cycles after last accept.
//  2. Same stub, m_ready toggling 1-0-1-0 and s_valid gapped every third cycle
//     -> no lost or duplicated samples/bins; outputs held while stalled; s_ready=0 during WAIT/CAPT/UNLOAD.
//  3. s_last asserted on the 10th sample
//     -> one err_frame pulse, no m_valid; next clean 32-sample frame is output correctly with indices 0..31.
//  4. s_last missing on the 32nd sample
//     -> err_frame pulse in the accept cycle and the frame is still output in full.
//  5. rst low during UNLOAD at bin 12
//     -> all outputs 0 asynchronously; after release s_ready=1 within 2 cycles; no stale bins emitted.
//  6. Real FFT top, impulse in0=0x0100 and rest 0
//     -> all 32 m_data_r equal and nonzero, all m_data_i=0; the next frame of all zeros -> 32 zero bins.

Source files
------------

// File: rtl/fft32_frame_ctrl_if.sv
// Sample-in / bin-out streaming handshake for the 32-point FFT frame controller.
// The master side is the sample source and result sink; the slave side is the controller.
interface fft32_frame_ctrl_if #(
  parameter int N = 16
);
  logic                s_valid;
  logic                s_ready;
  logic signed [N-1:0] s_data;
  logic                s_last;
  logic                m_valid;
  logic                m_ready;
  logic signed [N-1:0] m_data_r;
  logic signed [N-1:0] m_data_i;
  logic [4:0]          m_index;
  logic                m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data_r, m_data_i, m_index, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data_r, m_data_i, m_index, m_last
  );
endinterface

// File: rtl/fft32_frame_ctrl.sv
// Frame sequencer for a 32-point FFT: gathers 32 serial samples into a parallel bus,
// waits the FFT latency, snapshots all bins, then streams them out bin 0 first.
module fft32_frame_ctrl #(
  parameter int N       = 16,
  parameter int Q       = 8,
  parameter int FFT_LAT = 6
) (
  input  logic              clk2,
  input  logic              rst,
  fft32_frame_ctrl_if.slave io,
  output logic [32*N-1:0]   fft_in,
  input  logic [32*N-1:0]   fft_out_r,
  input  logic [32*N-1:0]   fft_out_i,
  output logic              busy,
  output logic              err_frame
);
  localparam int CW = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

  if (Q < 0 || Q >= N || FFT_LAT < 1) begin : g_bad_params
    $error("fft32_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_UNLOAD
  } state_t;

  state_t              state;
  logic [4:0]          wr_idx;
  logic [4:0]          rd_idx;
  logic [CW-1:0]       lat_cnt;
  logic                s_ready_q;
  logic                m_valid_q;
  logic                m_last_q;
  logic signed [N-1:0] ibuf   [32];
  logic signed [N-1:0] obuf_r [32];
  logic signed [N-1:0] obuf_i [32];

  // ibuf is only written on accepts in LOAD, so fft_in is frozen from WAIT through UNLOAD.
  always_comb begin
    fft_in = '0;
    for (int k = 0; k < 32; k++) begin
      fft_in[k*N +: N] = ibuf[k];
    end
  end

  assign io.s_ready  = s_ready_q;
  assign io.m_valid  = m_valid_q;
  assign io.m_last   = m_last_q;
  assign io.m_index  = rd_idx;
  assign io.m_data_r = obuf_r[rd_idx];
  assign io.m_data_i = obuf_i[rd_idx];

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wr_idx    <= '0;
      rd_idx    <= '0;
      lat_cnt   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy      <= 1'b0;
      err_frame <= 1'b0;
      for (int k = 0; k < 32; k++) begin
        ibuf[k]   <= '0;
        obuf_r[k] <= '0;
        obuf_i[k] <= '0;
      end
    end else begin
      err_frame <= 1'b0;
      case (state)
        S_IDLE: begin
          state     <= S_LOAD;
          s_ready_q <= 1'b1;
        end

        S_LOAD: begin
          if (io.s_valid && s_ready_q) begin
            if (wr_idx == 5'd31) begin
              // A missing s_last is flagged, but the full frame still goes through.
              ibuf[wr_idx] <= io.s_data;
              wr_idx       <= '0;
              lat_cnt      <= CW'(FFT_LAT - 1);
              state        <= S_WAIT;
              s_ready_q    <= 1'b0;
              busy         <= 1'b1;
              err_frame    <= !io.s_last;
            end else if (io.s_last) begin
              // Early s_last: drop this sample and the partial frame, restart at slot 0.
              wr_idx    <= '0;
              err_frame <= 1'b1;
            end else begin
              ibuf[wr_idx] <= io.s_data;
              wr_idx       <= wr_idx + 5'd1;
            end
          end
        end

        S_WAIT: begin
          if (lat_cnt == '0) begin
            state <= S_CAPT;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end

        S_CAPT: begin
          for (int k = 0; k < 32; k++) begin
            obuf_r[k] <= fft_out_r[k*N +: N];
            obuf_i[k] <= fft_out_i[k*N +: N];
          end
          rd_idx    <= '0;
          m_valid_q <= 1'b1;
          m_last_q  <= 1'b0;
          state     <= S_UNLOAD;
        end

        S_UNLOAD: begin
          if (io.m_ready) begin
            rd_idx   <= rd_idx + 5'd1;
            m_last_q <= (rd_idx == 5'd30);
            if (rd_idx == 5'd31) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy      <= 1'b0;
              s_ready_q <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft32_frame_ctrl.sv
// Directed bench for fft32_frame_ctrl with a delayed FFT stand-in (echo or reference DFT)
// and a scoreboard of expected bins filled when each frame is sent.
module tb_fft32_frame_ctrl;
  localparam int N   = 16;
  localparam int LAT = 6;
  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic            clk2 = 1'b0;
  logic            rst  = 1'b0;
  logic [32*N-1:0] fft_in;
  logic [32*N-1:0] fft_out_r;
  logic [32*N-1:0] fft_out_i;
  logic            busy;
  logic            err_frame;
  bit              stub_dft = 1'b0;
  logic [32*N-1:0] dl_r [LAT];
  logic [32*N-1:0] dl_i [LAT];

  int   checks   = 0;
  int   failures = 0;
  int   cyc_since = 0;
  exp_t sbq[$];

  fft32_frame_ctrl_if #(.N(N)) io ();

  fft32_frame_ctrl #(.N(N), .Q(8), .FFT_LAT(LAT)) dut (
    .clk2      (clk2),
    .rst       (rst),
    .io        (io),
    .fft_in    (fft_in),
    .fft_out_r (fft_out_r),
    .fft_out_i (fft_out_i),
    .busy      (busy),
    .err_frame (err_frame)
  );

  always #5 clk2 = ~clk2;

  function automatic logic [32*N-1:0] model_r(input logic [32*N-1:0] x, input bit dft);
    logic [32*N-1:0] y;
    real acc;
    y = x;
    if (dft) begin
      for (int k = 0; k < 32; k++) begin
        acc = 0.0;
        for (int n = 0; n < 32; n++)
          acc += $itor($signed(x[n*N +: N])) * $cos(2.0 * PI * k * n / 32.0);
        y[k*N +: N] = N'($rtoi(acc + ((acc >= 0.0) ? 0.5 : -0.5)));
      end
    end
    return y;
  endfunction

  function automatic logic [32*N-1:0] model_i(input logic [32*N-1:0] x, input bit dft);
    logic [32*N-1:0] y;
    real acc;
    y = ~x;
    if (dft) begin
      for (int k = 0; k < 32; k++) begin
        acc = 0.0;
        for (int n = 0; n < 32; n++)
          acc -= $itor($signed(x[n*N +: N])) * $sin(2.0 * PI * k * n / 32.0);
        y[k*N +: N] = N'($rtoi(acc + ((acc >= 0.0) ? 0.5 : -0.5)));
      end
    end
    return y;
  endfunction

  // FFT stand-in: LAT register stages after fft_in, so output settles exactly LAT cycles later.
  always @(posedge clk2) begin
    dl_r[0] <= model_r(fft_in, stub_dft);
    dl_i[0] <= model_i(fft_in, stub_dft);
    for (int s = 1; s < LAT; s++) begin
      dl_r[s] <= dl_r[s-1];
      dl_i[s] <= dl_i[s-1];
    end
  end
  assign fft_out_r = dl_r[LAT-1];
  assign fft_out_i = dl_i[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
    cyc_since++;
  endtask

  // kind 0: ramp base+i; kind 1: impulse 0x0100 at sample 0; kind 2: all zeros
  function automatic logic [15:0] sval(input int kind, input int base, input int i);
    if (kind == 0) return 16'(base + i);
    if (kind == 1) return (i == 0) ? 16'h0100 : 16'h0000;
    return 16'h0000;
  endfunction

  task automatic push_frame(input int kind, input int base);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.idx  = 5'(k);
      e.last = (k == 31);
      if (kind == 0) begin
        e.r = 16'(base + k);
        e.i = ~16'(base + k);
      end else if (kind == 1) begin
        e.r = 16'h0100;
        e.i = 16'h0000;
      end else begin
        e.r = 16'h0000;
        e.i = 16'h0000;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic send_frame(input int len, input int last_pos, input bit gap,
                            input int kind, input int base);
    int i = 0;
    int cyc = 0;
    bit acc;
    bit err_exp;
    while (i < len && cyc < 400) begin
      io.s_valid = !(gap && (cyc % 3 == 2));
      io.s_data  = sval(kind, base, i);
      io.s_last  = (i == last_pos);
      acc        = io.s_valid && io.s_ready;
      err_exp    = acc && ((i == 31) != (i == last_pos));
      tick();
      cyc++;
      check("err_frame", {31'b0, err_frame}, {31'b0, err_exp});
      if (acc) begin
        if (i == 31) cyc_since = 1;
        i++;
      end
    end
    io.s_valid = 1'b0;
    io.s_last  = 1'b0;
    if (i < len) check("send_timeout", 32'(i), 32'(len));
  endtask

  task automatic receive_frame(input bit toggle, input int stop_at);
    int   got = 0;
    int   cyc = 0;
    bit   first = 1'b1;
    bit   held = 1'b0;
    logic [15:0] hr, hi;
    logic [4:0]  hidx;
    exp_t e;
    while (got < stop_at && cyc < 600) begin
      io.m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      check("s_ready_busy", {31'b0, io.s_ready}, 32'd0);
      if (io.m_valid) begin
        if (first) begin
          check("first_valid_latency", 32'(cyc_since), 32'd8);
          first = 1'b0;
        end
        if (held) begin
          check("hold_r", {16'b0, $unsigned(io.m_data_r)}, {16'b0, hr});
          check("hold_i", {16'b0, $unsigned(io.m_data_i)}, {16'b0, hi});
          check("hold_idx", {27'b0, io.m_index}, {27'b0, hidx});
        end
        if (io.m_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_bin", {27'b0, io.m_index}, 32'hffffffff);
          end else begin
            e = sbq.pop_front();
            check("m_data_r", {16'b0, $unsigned(io.m_data_r)}, {16'b0, e.r});
            check("m_data_i", {16'b0, $unsigned(io.m_data_i)}, {16'b0, e.i});
            check("m_index", {27'b0, io.m_index}, {27'b0, e.idx});
            check("m_last", {31'b0, io.m_last}, {31'b0, e.last});
          end
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hr   = io.m_data_r;
          hi   = io.m_data_i;
          hidx = io.m_index;
        end
      end else begin
        check("busy_wait", {31'b0, busy}, 32'd1);
      end
      tick();
      cyc++;
    end
    io.m_ready = 1'b1;
    if (got < stop_at) check("recv_timeout", 32'(got), 32'(stop_at));
    if (stop_at == 32) begin
      check("m_valid_drop", {31'b0, io.m_valid}, 32'd0);
      check("s_ready_reload", {31'b0, io.s_ready}, 32'd1);
      check("busy_drop", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    bit seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (io.m_valid) seen = 1'b1;
      tick();
    end
    check(tag, {31'b0, seen}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, {31'b0, io.s_ready}, 32'd0);
    check({tag, "_m_valid"}, {31'b0, io.m_valid}, 32'd0);
    check({tag, "_m_last"}, {31'b0, io.m_last}, 32'd0);
    check({tag, "_m_index"}, {27'b0, io.m_index}, 32'd0);
    check({tag, "_m_data"}, {$unsigned(io.m_data_r), $unsigned(io.m_data_i)}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_err"}, {31'b0, err_frame}, 32'd0);
    check({tag, "_fft_in_zero"}, {31'b0, (fft_in == '0)}, 32'd1);
  endtask

  task automatic release_reset(input string tag);
    int w = 0;
    #3 rst = 1'b1;
    while (!io.s_ready && w < 3) begin
      tick();
      w++;
    end
    check({tag, "_s_ready_up"}, {31'b0, io.s_ready}, 32'd1);
    check({tag, "_s_ready_cycles_ok"}, {31'b0, (w >= 1 && w <= 2)}, 32'd1);
  endtask

  initial begin
    io.s_valid = 1'b0;
    io.s_data  = '0;
    io.s_last  = 1'b0;
    io.m_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("por");
    release_reset("por");

    // Frame 1: ramp 0..31, sink always ready
    push_frame(0, 0);
    send_frame(32, 31, 1'b0, 0, 0);
    receive_frame(1'b0, 32);

    // Frame 2: gapped source, stalling sink
    push_frame(0, 16'h7fe0);
    send_frame(32, 31, 1'b1, 0, 16'h7fe0);
    receive_frame(1'b1, 32);

    // Early s_last on 10th sample, then a clean frame
    send_frame(10, 9, 1'b0, 0, 500);
    expect_quiet("partial_no_output", 20);
    check("partial_s_ready", {31'b0, io.s_ready}, 32'd1);
    push_frame(0, 1000);
    send_frame(32, 31, 1'b0, 0, 1000);
    receive_frame(1'b0, 32);

    // Missing s_last on the 32nd sample
    push_frame(0, 2000);
    send_frame(32, -1, 1'b1, 0, 2000);
    receive_frame(1'b0, 32);

    // Reset in the middle of unloading, at bin 12
    push_frame(0, 3000);
    send_frame(32, 31, 1'b0, 0, 3000);
    receive_frame(1'b0, 12);
    check("pre_reset_index", {27'b0, io.m_index}, 32'd12);
    check("pre_reset_valid", {31'b0, io.m_valid}, 32'd1);
    rst = 1'b0;
    #2;
    check_reset_outputs("mid");
    sbq.delete();
    tick();
    release_reset("mid");
    expect_quiet("no_stale_bins", 16);
    push_frame(0, 4000);
    send_frame(32, 31, 1'b0, 0, 4000);
    receive_frame(1'b1, 32);

    // Reference DFT stand-in: impulse then all-zero frame
    stub_dft = 1'b1;
    push_frame(1, 0);
    send_frame(32, 31, 1'b0, 1, 0);
    receive_frame(1'b0, 32);
    push_frame(2, 0);
    send_frame(32, 31, 1'b1, 2, 0);
    receive_frame(1'b1, 32);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
